// File: rtl/ex_mem_pipe_pkg.sv
// Shared opcode and flag-bit constants for the EX/MEM boundary.
// The ALU stage and decode import this same package.
package ex_mem_pipe_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_RED    = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LHB    = 4'b1010;
  localparam logic [3:0] OP_LLB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  // Per-bit flag write mask for an opcode.
  function automatic logic [2:0] flag_we_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB: begin
        m[FLAG_Z] = 1'b1;
        m[FLAG_V] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_flag_reg.sv
// Architectural Z/V/N register with per-bit write enable and a bypass
// output showing the value it will hold after the next edge.
module flag_reg
  import ex_mem_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] we,
  input  logic [2:0] din,
  output logic [2:0] flags,
  output logic [2:0] flags_fwd
);

  logic [2:0] flags_d, flags_q;

  always_comb begin
    flags_d = (we & din) | (~we & flags_q);
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= 3'b000;
    else     flags_q <= flags_d;
  end

  assign flags     = flags_q;
  assign flags_fwd = flags_d;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: latches ALU outputs for MEM, owns the flag
// register and the sticky halt latch.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [3:0]    ex_opcode,
  input  logic [DW-1:0] ex_addr,
  input  logic [DW-1:0] ex_result,
  input  logic [2:0]    ex_flag,
  input  logic [DW-1:0] ex_pc2,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_write,
  output logic          mem_valid,
  output logic [3:0]    mem_opcode,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_write,
  output logic          mem_read,
  output logic          mem_write,
  output logic [2:0]    flags,
  output logic [2:0]    flags_fwd,
  output logic          halted
);

  logic          acc;
  logic [2:0]    flag_we;
  logic          valid_d, valid_q;
  logic [3:0]    opcode_d, opcode_q;
  logic [DW-1:0] addr_d, addr_q;
  logic [DW-1:0] data_d, data_q;
  logic [RW-1:0] rd_d, rd_q;
  logic          reg_write_d, reg_write_q;
  logic          read_d, read_q;
  logic          write_d, write_q;
  logic          halted_d, halted_q;

  assign acc     = ex_valid & ~flush & ~stall & ~halted_q;
  assign flag_we = acc ? flag_we_mask(ex_opcode) : 3'b000;

  always_comb begin
    valid_d     = valid_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    read_d      = read_q;
    write_d     = write_q;
    halted_d    = halted_q;
    if (acc) begin
      valid_d     = 1'b1;
      opcode_d    = ex_opcode;
      addr_d      = ex_addr;
      data_d      = (ex_opcode == OP_PCS) ? ex_pc2 : ex_result;
      rd_d        = ex_rd;
      read_d      = (ex_opcode == OP_LW);
      write_d     = (ex_opcode == OP_SW);
      reg_write_d = ex_reg_write & (ex_opcode != OP_SW);
      halted_d    = halted_q | (ex_opcode == OP_HLT);
    end else if (!stall) begin
      // Bubble: kill the control bits, leave the data fields as they were.
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      read_d      = 1'b0;
      write_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      read_q      <= read_d;
      write_q     <= write_d;
      halted_q    <= halted_d;
    end
  end

  flag_reg u_flag_reg (
    .clk       (clk),
    .rst       (rst),
    .we        (flag_we),
    .din       (ex_flag),
    .flags     (flags),
    .flags_fwd (flags_fwd)
  );

  assign mem_valid     = valid_q;
  assign mem_opcode    = opcode_q;
  assign mem_addr      = addr_q;
  assign mem_data      = data_q;
  assign mem_rd        = rd_q;
  assign mem_reg_write = reg_write_q;
  assign mem_read      = read_q;
  assign mem_write     = write_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: a behavioural model checked every cycle
// plus literal expectations at the interesting points of the sequence.
module tb_ex_mem_pipe;

  localparam int DW = 16;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst, stall, flush, ex_valid, ex_reg_write;
  logic [3:0]    ex_opcode;
  logic [DW-1:0] ex_addr, ex_result, ex_pc2;
  logic [2:0]    ex_flag;
  logic [RW-1:0] ex_rd;
  logic          mem_valid, mem_reg_write, mem_read, mem_write, halted;
  logic [3:0]    mem_opcode;
  logic [DW-1:0] mem_addr, mem_data;
  logic [RW-1:0] mem_rd;
  logic [2:0]    flags, flags_fwd;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mem_pipe #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_addr(ex_addr),
    .ex_result(ex_result), .ex_flag(ex_flag), .ex_pc2(ex_pc2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .flags(flags),
    .flags_fwd(flags_fwd), .halted(halted)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic          m_valid = 0, m_rw = 0, m_rd_en = 0, m_wr = 0, m_halt = 0;
  logic [3:0]    m_op = 0;
  logic [DW-1:0] m_addr = 0, m_data = 0;
  logic [RW-1:0] m_rd = 0;
  logic [2:0]    m_flags = 0;
  logic          model_live = 0;

  function automatic logic [2:0] model_next_flags(input logic [2:0] cur);
    logic [2:0] f;
    f = cur;
    if (ex_valid && !flush && !stall && !m_halt) begin
      if (ex_opcode == 4'd0 || ex_opcode == 4'd1) f = ex_flag;
      else if (ex_opcode >= 4'd3 && ex_opcode <= 4'd6) f[0] = ex_flag[0];
    end
    return f;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      {m_valid, m_rw, m_rd_en, m_wr, m_halt} = '0;
      m_op = 0; m_addr = 0; m_data = 0; m_rd = 0; m_flags = 0;
      model_live = 1;
    end else if (!stall) begin
      m_flags = model_next_flags(m_flags);
      if (ex_valid && !flush && !m_halt) begin
        m_valid = 1;
        m_op    = ex_opcode;
        m_addr  = ex_addr;
        m_data  = (ex_opcode == 4'd14) ? ex_pc2 : ex_result;
        m_rd    = ex_rd;
        m_rd_en = (ex_opcode == 4'd8);
        m_wr    = (ex_opcode == 4'd9);
        m_rw    = ex_reg_write && !m_wr;
        if (ex_opcode == 4'd15) m_halt = 1;
      end else begin
        m_valid = 0; m_rw = 0; m_rd_en = 0; m_wr = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("m.mem_valid", mem_valid, m_valid);
      check("m.mem_reg_write", mem_reg_write, m_rw);
      check("m.mem_read", mem_read, m_rd_en);
      check("m.mem_write", mem_write, m_wr);
      check("m.halted", halted, m_halt);
      check("m.flags", flags, m_flags);
      check("m.flags_fwd", flags_fwd, rst ? flags : model_next_flags(m_flags));
      if (m_valid) begin
        check("m.mem_opcode", mem_opcode, m_op);
        check("m.mem_addr", mem_addr, m_addr);
        check("m.mem_data", mem_data, m_data);
        check("m.mem_rd", mem_rd, m_rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [3:0] op, input logic [2:0] fl,
                        input logic [DW-1:0] addr, input logic [DW-1:0] res,
                        input logic [RW-1:0] rd, input logic rw);
    ex_valid = 1; ex_opcode = op; ex_flag = fl; ex_addr = addr;
    ex_result = res; ex_rd = rd; ex_reg_write = rw;
  endtask

  initial begin
    rst = 0; stall = 0; flush = 0; ex_valid = 0; ex_opcode = 0; ex_addr = 0;
    ex_result = 0; ex_flag = 0; ex_pc2 = 0; ex_rd = 0; ex_reg_write = 0;
    #2;
    // Reset with an ADD sitting in EX
    rst = 1; set_ex(4'd0, 3'b111, 16'h1234, 16'h5678, 4'd2, 1);
    tick();
    rst = 0; ex_valid = 0;
    check("rst.mem_valid", mem_valid, 0);
    check("rst.mem_data", mem_data, 0);
    check("rst.mem_opcode", mem_opcode, 0);
    check("rst.flags", flags, 3'b000);
    check("rst.halted", halted, 0);
    tick();

    // SUB then XOR
    set_ex(4'd1, 3'b111, 16'h0010, 16'h0000, 4'd1, 1);
    tick();
    check("sub.flags", flags, 3'b111);
    set_ex(4'd3, 3'b000, 16'h0011, 16'h00FF, 4'd2, 1);
    #1 check("xor.flags_fwd", flags_fwd, 3'b110);
    tick();
    check("xor.flags", flags, 3'b110);

    // Set flags to 101, then no-write opcodes
    set_ex(4'd0, 3'b101, 16'h0000, 16'h0001, 4'd3, 1);
    tick();
    check("add.flags", flags, 3'b101);
    set_ex(4'd2, 3'b010, 16'h0020, 16'h0002, 4'd4, 1);
    tick();
    check("red.flags", flags, 3'b101);
    check("red.mem_read", mem_read, 0);
    set_ex(4'd7, 3'b010, 16'h0021, 16'h0003, 4'd5, 1);
    tick();
    check("paddsb.flags", flags, 3'b101);
    check("paddsb.mem_read", mem_read, 0);
    set_ex(4'd8, 3'b010, 16'h0022, 16'h0004, 4'd6, 1);
    tick();
    check("lw.flags", flags, 3'b101);
    check("lw.mem_read", mem_read, 1);
    check("lw.mem_reg_write", mem_reg_write, 1);

    // SW, then stall+flush (flush ignored), then flush alone
    set_ex(4'd9, 3'b111, 16'h0040, 16'hBEEF, 4'd7, 1);
    tick();
    check("sw.mem_write", mem_write, 1);
    check("sw.mem_reg_write", mem_reg_write, 0);
    set_ex(4'd0, 3'b010, 16'h0099, 16'h1111, 4'd8, 1);
    stall = 1; flush = 1;
    #1 check("stall.flags_fwd", flags_fwd, 3'b101);
    tick();
    tick();
    check("stall.mem_valid", mem_valid, 1);
    check("stall.mem_write", mem_write, 1);
    check("stall.mem_addr", mem_addr, 16'h0040);
    check("stall.mem_data", mem_data, 16'hBEEF);
    check("stall.flags", flags, 3'b101);
    stall = 0;
    tick();
    check("flush.mem_valid", mem_valid, 0);
    check("flush.mem_write", mem_write, 0);
    check("flush.flags", flags, 3'b101);
    flush = 0;

    // PCS selects PC+2
    set_ex(4'd14, 3'b111, 16'h0000, 16'hFFFF, 4'd9, 1);
    ex_pc2 = 16'h0102;
    tick();
    check("pcs.mem_data", mem_data, 16'h0102);
    check("pcs.mem_reg_write", mem_reg_write, 1);
    check("pcs.flags", flags, 3'b101);

    // Bubble then SLL writes Z only
    ex_valid = 0;
    tick();
    check("bubble.mem_valid", mem_valid, 0);
    set_ex(4'd4, 3'b010, 16'h0000, 16'h0004, 4'd1, 1);
    tick();
    check("sll.flags", flags, 3'b100);

    // HLT freezes the stage
    set_ex(4'd15, 3'b111, 16'h0000, 16'h0000, 4'd0, 0);
    tick();
    check("hlt.halted", halted, 1);
    check("hlt.mem_opcode", mem_opcode, 4'hF);
    check("hlt.mem_valid", mem_valid, 1);
    set_ex(4'd0, 3'b111, 16'h0000, 16'h0000, 4'd1, 1);
    #1 check("hlt.flags_fwd", flags_fwd, 3'b100);
    tick();
    check("post_hlt.mem_valid", mem_valid, 0);
    check("post_hlt.flags", flags, 3'b100);
    tick();
    check("post_hlt.halted", halted, 1);
    rst = 1;
    tick();
    rst = 0;
    check("clr.halted", halted, 0);
    set_ex(4'd0, 3'b010, 16'h0000, 16'h0000, 4'd1, 1);
    tick();
    check("clr.flags", flags, 3'b010);
    check("clr.mem_valid", mem_valid, 1);
    ex_valid = 0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
